float_div_module: RTL
=====================

// Module: float_div_module
// PURPOSE
//   Iterative IEEE-754 single-precision divider, Result = A / B; companion to the float multiplier datapath.
//   Restoring mantissa division, one quotient bit per cycle, fixed latency for every operand pair.
//   Same Start_Sig / Done_Sig handshake as the multiplier, so either unit can sit behind the same control FSM.
//   Denormal inputs are flushed to zero. Inf/NaN inputs are not special-cased; the caller guarantees finite operands.
// PARAMETERS
//   ROUND_EN   1             1: round-half-up on the first discarded quotient bit; 0: truncate
//   NAN_VALUE  32'h7FC00000  result for 0/0
// PORTS
//   CLK        in   1   clock, rising edge
//   RST        in   1   asynchronous, active-high reset
//   Start_Sig  in   1   request; sampled only in IDLE
//   A          in   32  dividend; captured on the accepting edge
//   B          in   32  divisor; captured on the accepting edge
//   Busy       out  1   high from the accepting edge until return to IDLE
//   Result     out  32  quotient; held until the next accepted start
//   Done_Sig   out  4   {isOver, isUnder, isZero, isDone}
//   DivZero    out  1   B was zero (exponent field 0); held like Result
// BEHAVIOUR
//   Reset: state IDLE; Result, Done_Sig, DivZero, Busy all 0; internal regs 0. Reset mid-operation aborts immediately.
//   FSM: IDLE -> UNPACK -> DIVIDE (26 cycles) -> NORM -> PACK -> DONE -> IDLE.
//   Accept edge = edge 0: A/B latched, Busy<=1, flags cleared.
//   Edge 29: Result, flags and isDone<=1 are written. Edge 30: isDone<=0, Busy<=0, back to IDLE.
//   Latency is always 30 edges, including special cases; the datapath runs and PACK overrides the result.
//   Start_Sig is ignored while Busy. Start_Sig held high in IDLE re-triggers on the edge after DONE.
//   UNPACK: sign = A[31]^B[31].
//     mA = {1, A[22:0]}, or 0 if A[30:23] == 0.
//     mB = {1, B[22:0]}, or 0 if B[30:23] == 0.
//     E = A[30:23] - B[30:23] + 127, 10-bit signed.
//   DIVIDE: R (26b) = mA initially. Per cycle k = 25..0:
//     if R >= mB then Q[k] = 1, R = R - mB; else Q[k] = 0.
//     then R = R << 1.
//     Result: Q = floor(mA * 2^25 / mB), with Q in [2^24, 2^26) for normal operands.
//   NORM:
//     Q[25] = 1: frac = Q[24:2], rbit = Q[1], exponent = E.
//     Q[25] = 0: frac = Q[23:1], rbit = Q[0], exponent = E - 1.
//   PACK rounding: if ROUND_EN and rbit, frac = frac + 1.
//     On carry out of frac: frac = 0, exponent = exponent + 1.
//   PACK priority, highest first:
//     1. A zero and B zero: Result = NAN_VALUE; DivZero = 1, isZero = 1.
//     2. B zero: Result = {sign, 8'hFF, 23'd0}; DivZero = 1.
//     3. A zero: Result = {sign, 31'd0}; isZero = 1.
//     4. exponent >= 255: Result = {sign, 8'hFF, 23'd0}; isOver = 1.
//     5. exponent <= 0: Result = {sign, 31'd0}; isUnder = 1.
//     6. otherwise: Result = {sign, exponent[7:0], frac}.
//   isOver, isUnder, isZero and DivZero stay valid after isDone drops, until the next accept.
// TESTING
//   1. A=40C00000, B=40000000, single Start pulse -> Result=40400000 at edge 29; isDone high 1 cycle; flags 0; Busy 30 cycles.
//   2. A=3F800000, B=40400000 -> 3EAAAAAB (ROUND_EN=1); 3EAAAAAA (ROUND_EN=0).
//   3. A=3F800000, B=0 -> 7F800000, DivZero=1.
//      A=BF800000, B=0 -> FF800000.
//      A=0, B=0 -> 7FC00000, DivZero=1, isZero=1.
//   4. A=7F000000, B=00800000 -> 7F800000, isOver=1.
//      A=00800000, B=7F000000 -> 00000000, isUnder=1.
//   5. A=C0C00000, B=40000000 -> C0400000.
//      A=3F800000, B=3F800000 -> 3F800000.
//   6. Start pulse during DIVIDE: ignored, first result intact.
//      RST at edge 10 -> Result, Done_Sig, DivZero, Busy = 0 immediately.
//      Next start after RST -> correct result 30 edges later.

Source files
------------

// File: rtl/float_div_module.sv
// Iterative IEEE-754 single-precision divider, Result = A / B (restoring, one quotient bit per cycle).
// Latency: fixed 30 edges from the accepting edge to the return to IDLE; the result is written on edge 29.
// Backpressure: Start_Sig is sampled only in IDLE; requests that arrive while Busy are dropped.
module float_div_module #(
  parameter bit          ROUND_EN  = 1'b1,
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start_Sig,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Result,
  output logic [3:0]  Done_Sig,
  output logic        DivZero
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    NORM   = 3'd3,
    PACK   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operands as captured on the accepting edge
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;

  // Unpacked operands
  logic              sign;
  logic              a_zero;
  logic              b_zero;
  logic [23:0]       m_b;
  logic signed [9:0] exp_e;

  // Division state
  logic [25:0]       rem;
  logic [25:0]       quo;
  logic [4:0]        cnt;

  // Normalised quotient
  logic [22:0]       frac;
  logic              rbit;
  logic signed [9:0] exp_n;

  // Combinational helpers
  logic              a_is_zero;
  logic              b_is_zero;
  logic [23:0]       m_a_unp;
  logic [23:0]       m_b_unp;
  logic signed [9:0] exp_unp;
  logic              rem_ge;
  logic [25:0]       rem_sub;
  logic [23:0]       frac_rnd;
  logic signed [9:0] exp_r;
  logic [31:0]       pack_result;
  logic              pack_over;
  logic              pack_under;
  logic              pack_zero;
  logic              pack_dz;

  // State register; reset aborts any operation in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed sequence, DIVIDE runs until the bit counter reaches 0
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start_Sig) state_nxt = UNPACK;
      UNPACK:  state_nxt = DIVIDE;
      DIVIDE:  if (cnt == 5'd0) state_nxt = NORM;
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Unpack: denormals (exponent field 0) flush to a zero mantissa
  always_comb begin
    a_is_zero = (a_reg[30:23] == 8'd0);
    b_is_zero = (b_reg[30:23] == 8'd0);
    m_a_unp   = a_is_zero ? 24'd0 : {1'b1, a_reg[22:0]};
    m_b_unp   = b_is_zero ? 24'd0 : {1'b1, b_reg[22:0]};
    exp_unp   = $signed({2'b00, a_reg[30:23]}) - $signed({2'b00, b_reg[30:23]}) + 10'sd127;
  end

  // One restoring-division step: trial subtract, keep on success, then shift
  always_comb begin
    rem_ge  = (rem >= {2'b00, m_b});
    rem_sub = rem_ge ? (rem - {2'b00, m_b}) : rem;
  end

  // Rounding and result selection; zero/div-zero cases override the datapath value
  always_comb begin
    frac_rnd = {1'b0, frac};
    if (ROUND_EN && rbit) begin
      frac_rnd = frac_rnd + 24'd1;
    end
    exp_r = exp_n;
    if (frac_rnd[23]) begin
      exp_r = exp_n + 10'sd1;
    end
    pack_result = {sign, exp_r[7:0], frac_rnd[22:0]};
    pack_over   = 1'b0;
    pack_under  = 1'b0;
    pack_zero   = 1'b0;
    pack_dz     = 1'b0;
    if (a_zero && b_zero) begin
      pack_result = NAN_VALUE;
      pack_dz     = 1'b1;
      pack_zero   = 1'b1;
    end else if (b_zero) begin
      pack_result = {sign, 8'hFF, 23'd0};
      pack_dz     = 1'b1;
    end else if (a_zero) begin
      pack_result = {sign, 31'd0};
      pack_zero   = 1'b1;
    end else if (exp_r >= 10'sd255) begin
      pack_result = {sign, 8'hFF, 23'd0};
      pack_over   = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      pack_result = {sign, 31'd0};
      pack_under  = 1'b1;
    end
  end

  // Datapath and output registers, advanced according to the current state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_reg    <= 32'd0;
      b_reg    <= 32'd0;
      sign     <= 1'b0;
      a_zero   <= 1'b0;
      b_zero   <= 1'b0;
      m_b      <= 24'd0;
      exp_e    <= 10'sd0;
      rem      <= 26'd0;
      quo      <= 26'd0;
      cnt      <= 5'd0;
      frac     <= 23'd0;
      rbit     <= 1'b0;
      exp_n    <= 10'sd0;
      Busy     <= 1'b0;
      Result   <= 32'd0;
      Done_Sig <= 4'd0;
      DivZero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start_Sig) begin
            a_reg    <= A;
            b_reg    <= B;
            Busy     <= 1'b1;
            Done_Sig <= 4'd0;
            DivZero  <= 1'b0;
          end
        end
        UNPACK: begin
          sign   <= a_reg[31] ^ b_reg[31];
          a_zero <= a_is_zero;
          b_zero <= b_is_zero;
          m_b    <= m_b_unp;
          exp_e  <= exp_unp;
          rem    <= {2'b00, m_a_unp};
          quo    <= 26'd0;
          cnt    <= 5'd25;
        end
        DIVIDE: begin
          // Quotient bits arrive MSB first, so shifting in from the LSB lands bit k at Q[k]
          quo <= {quo[24:0], rem_ge};
          rem <= rem_sub << 1;
          cnt <= cnt - 5'd1;
        end
        NORM: begin
          if (quo[25]) begin
            frac  <= quo[24:2];
            rbit  <= quo[1];
            exp_n <= exp_e;
          end else begin
            frac  <= quo[23:1];
            rbit  <= quo[0];
            exp_n <= exp_e - 10'sd1;
          end
        end
        PACK: begin
          Result   <= pack_result;
          Done_Sig <= {pack_over, pack_under, pack_zero, 1'b1};
          DivZero  <= pack_dz;
        end
        DONE: begin
          Done_Sig[0] <= 1'b0;
          Busy        <= 1'b0;
        end
        default: begin
          Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
